// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared definitions for the ALU issue stage.
//   XLEN / RF_ADDR_W : operand width and register index width
//   OPC_*            : RV64 major opcodes recognised by the decoder
//   cls_e            : instruction class reported to execute
//   issue_entry_t    : one fully decoded issue entry (operands, codes, rd, pc)
//   state_e          : occupancy of the two-entry issue buffer
package alu_issue_pkg;

  localparam int XLEN      = 64;
  localparam int RF_ADDR_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_JUMP    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } cls_e;

  typedef struct packed {
    logic [XLEN-1:0]      rs1;
    logic [XLEN-1:0]      rs2;
    logic [XLEN-1:0]      pc;
    logic [2:0]           func3;
    logic [6:0]           func7;
    logic [RF_ADDR_W-1:0] rd;
    logic                 rd_we;
    cls_e                 cls;
    logic [2:0]           br_f3;
  } issue_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: purely combinational decode of one RV64 instruction into
// an issue entry for the 64-bit ALU.
//   instr, pc        : fetched instruction word and its PC
//   rdata1, rdata2   : regfile data for instr[19:15] / instr[24:20]
//   wb_we/wb_rd/wb_data : writeback bypass (only used when WB_FWD_EN is defined)
//   entry            : decoded operands, func3/func7, rd, class, branch func3, pc
// Build option: WB_FWD_EN -- bypass a same-cycle writeback onto the operands.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]          instr,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      rdata1,
  input  logic [XLEN-1:0]      rdata2,
  input  logic                 wb_we,
  input  logic [RF_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output issue_entry_t         entry
);

  logic [6:0]           opcode;
  logic [2:0]           f3;
  logic [6:0]           f7;
  logic [RF_ADDR_W-1:0] rd_idx;
  logic [RF_ADDR_W-1:0] rs1_idx;
  logic [RF_ADDR_W-1:0] rs2_idx;
  logic [XLEN-1:0]      imm_i;
  logic [XLEN-1:0]      imm_s;
  logic [XLEN-1:0]      imm_u;
  logic [XLEN-1:0]      shamt;
  logic [XLEN-1:0]      opa;
  logic [XLEN-1:0]      opb;

  assign opcode  = instr[6:0];
  assign rd_idx  = instr[11:7];
  assign f3      = instr[14:12];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];
  assign f7      = instr[31:25];

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
  // Shift-immediate forms hand the raw 6-bit shamt to the ALU; the funct7
  // bits above it are reported separately through func7.
  assign shamt = {{(XLEN-6){1'b0}}, instr[25:20]};

`ifdef WB_FWD_EN
  logic fwd1;
  logic fwd2;
  assign fwd1 = wb_we && (wb_rd == rs1_idx) && (rs1_idx != '0);
  assign fwd2 = wb_we && (wb_rd == rs2_idx) && (rs2_idx != '0);
  assign opa  = (rs1_idx == '0) ? '0 : (fwd1 ? wb_data : rdata1);
  assign opb  = (rs2_idx == '0) ? '0 : (fwd2 ? wb_data : rdata2);
`else
  logic wb_unused;
  assign wb_unused = ^{wb_we, wb_rd, wb_data};
  assign opa = (rs1_idx == '0) ? '0 : rdata1;
  assign opb = (rs2_idx == '0) ? '0 : rdata2;
`endif

  always_comb begin
    entry     = '0;
    entry.pc  = pc;
    entry.cls = CLS_ILLEGAL;
    case (opcode)
      OPC_OP: begin
        entry.cls   = CLS_ALU;
        entry.rs1   = opa;
        entry.rs2   = opb;
        entry.func3 = f3;
        entry.func7 = f7;
        entry.rd    = rd_idx;
        entry.rd_we = (rd_idx != '0);
      end
      OPC_OP_IMM: begin
        entry.cls   = CLS_ALU;
        entry.rs1   = opa;
        entry.rs2   = ((f3 == 3'd1) || (f3 == 3'd5)) ? shamt : imm_i;
        entry.func3 = f3;
        // Only the SRAI/SRLI distinction survives into func7.
        entry.func7 = (f3 == 3'd5) ? (f7 & 7'h20) : 7'h00;
        entry.rd    = rd_idx;
        entry.rd_we = (rd_idx != '0);
      end
      OPC_LOAD: begin
        entry.cls   = CLS_LOAD;
        entry.rs1   = opa;
        entry.rs2   = imm_i;
        entry.br_f3 = f3;
        entry.rd    = rd_idx;
        entry.rd_we = (rd_idx != '0);
      end
      OPC_STORE: begin
        entry.cls   = CLS_STORE;
        entry.rs1   = opa;
        entry.rs2   = imm_s;
        entry.br_f3 = f3;
      end
      OPC_BRANCH: begin
        entry.cls   = CLS_BRANCH;
        entry.rs1   = opa;
        entry.rs2   = opb;
        entry.func7 = 7'h20;
        entry.br_f3 = f3;
      end
      OPC_LUI: begin
        entry.cls   = CLS_ALU;
        entry.rs2   = imm_u;
        entry.rd    = rd_idx;
        entry.rd_we = (rd_idx != '0);
      end
      OPC_AUIPC: begin
        entry.cls   = CLS_ALU;
        entry.rs1   = pc;
        entry.rs2   = imm_u;
        entry.rd    = rd_idx;
        entry.rd_we = (rd_idx != '0);
      end
      OPC_JAL, OPC_JALR: begin
        // ALU computes the link address pc+4.
        entry.cls   = CLS_JUMP;
        entry.rs1   = pc;
        entry.rs2   = XLEN'(4);
        entry.rd    = rd_idx;
        entry.rd_we = (rd_idx != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue stage between fetch and the 64-bit ALU.
// Decodes at accept, holds up to two entries (main + skid) and presents the
// main entry to execute with valid/ready handshakes on both sides.
//   clk, rst_n, flush                 : clock, async active-low reset, sync drop-all
//   in_valid/in_ready/in_instr/in_pc  : fetch side (in_ready from state register)
//   rf_raddr1/2, rf_rdata1/2          : same-cycle regfile read
//   wb_we/wb_rd/wb_data               : writeback bypass (WB_FWD_EN only)
//   out_valid/out_ready, alu_*, out_* : issue entry to execute
// Build option: WB_FWD_EN -- see alu_issue_decode.
//
// state    | meaning
// ST_EMPTY | no entry held; in_ready=1, out_valid=0
// ST_ONE   | main entry valid, skid empty
// ST_FULL  | main and skid valid; in_ready=0
module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc,
  output logic [RF_ADDR_W-1:0] rf_raddr1,
  output logic [RF_ADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  input  logic                 wb_we,
  input  logic [RF_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      alu_rs1,
  output logic [XLEN-1:0]      alu_rs2,
  output logic [2:0]           alu_func3,
  output logic [6:0]           alu_func7,
  output logic [RF_ADDR_W-1:0] out_rd,
  output logic                 out_rd_we,
  output logic [2:0]           out_cls,
  output logic [2:0]           out_br_f3,
  output logic [XLEN-1:0]      out_pc
);

  state_e       state_q, state_d;
  issue_entry_t main_q, skid_q, dec_entry;
  logic         accept, issue;
  logic         load_main_in, load_main_skid, load_skid_in;

  assign rf_raddr1 = in_instr[19:15];
  assign rf_raddr2 = in_instr[24:20];

  alu_issue_decode u_decode (
    .instr   (in_instr),
    .pc      (in_pc),
    .rdata1  (rf_rdata1),
    .rdata2  (rf_rdata2),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .entry   (dec_entry)
  );

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign issue     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && issue) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d      = ST_FULL;
          load_skid_in = 1'b1;
        end else if (issue) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (issue) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over any handshake in the same cycle, including an accept.
    if (flush) begin
      state_d        = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= dec_entry;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid_in)        skid_q <= dec_entry;
    end
  end

  assign alu_rs1   = main_q.rs1;
  assign alu_rs2   = main_q.rs2;
  assign alu_func3 = main_q.func3;
  assign alu_func7 = main_q.func7;
  assign out_rd    = main_q.rd;
  assign out_rd_we = main_q.rd_we;
  assign out_cls   = main_q.cls;
  assign out_br_f3 = main_q.br_f3;
  assign out_pc    = main_q.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  typedef struct packed {
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  cls;
    logic [2:0]  br;
    logic [63:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc, rf_rdata1, rf_rdata2, wb_data;
  logic [4:0]  rf_raddr1, rf_raddr2, wb_rd, out_rd;
  logic        wb_we, out_rd_we;
  logic [63:0] alu_rs1, alu_rs2, out_pc;
  logic [2:0]  alu_func3, out_cls, out_br_f3;
  logic [6:0]  alu_func7;

  int   tests = 0;
  int   failed = 0;
  exp_t sb[$];
  exp_t pend;
  logic acc;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_func3(alu_func3), .alu_func7(alu_func7),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_cls(out_cls), .out_br_f3(out_br_f3),
    .out_pc(out_pc)
  );

  function automatic exp_t mk(input logic [63:0] rs1, input logic [63:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic we,
                              input logic [2:0] cls, input logic [2:0] br,
                              input logic [63:0] pc);
    exp_t e;
    e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.f7 = f7; e.rd = rd;
    e.we = we; e.cls = cls; e.br = br; e.pc = pc;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: at the falling edge score any issue against the queue front and
  // record an accept, then return just after the rising edge.
  task automatic tick(output logic accepted);
    exp_t e;
    @(negedge clk);
    accepted = in_valid && in_ready && !flush;
    if (out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("alu_rs1",   alu_rs1,           e.rs1);
        chk("alu_rs2",   alu_rs2,           e.rs2);
        chk("alu_func3", 64'(alu_func3),    64'(e.f3));
        chk("alu_func7", 64'(alu_func7),    64'(e.f7));
        chk("out_rd",    64'(out_rd),       64'(e.rd));
        chk("out_rd_we", 64'(out_rd_we),    64'(e.we));
        chk("out_cls",   64'(out_cls),      64'(e.cls));
        chk("out_br_f3", 64'(out_br_f3),    64'(e.br));
        chk("out_pc",    out_pc,            e.pc);
      end
    end
    if (accepted) sb.push_back(pend);
    if (flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [63:0] pc,
                      input logic [63:0] r1, input logic [63:0] r2, input exp_t e);
    logic a;
    int   n;
    in_instr  = instr;
    in_pc     = pc;
    rf_rdata1 = r1;
    rf_rdata2 = r2;
    pend      = e;
    in_valid  = 1'b1;
    n = 0;
    a = 1'b0;
    while (!a && n < 20) begin
      tick(a);
      n++;
    end
    chk("send_accepted", 64'(a), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic a;
    int   n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick(a);
      n++;
    end
    chk("drain_queue_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_pc = 64'h0; rf_rdata1 = 64'h0; rf_rdata2 = 64'h0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 64'h0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_alu_rs1",   alu_rs1,        64'd0);
    chk("rst_alu_rs2",   alu_rs2,        64'd0);
    chk("rst_out_pc",    out_pc,         64'd0);
    chk("rst_out_cls",   64'(out_cls),   64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD x3,x1,x2
    in_instr = 32'h002081B3; #1;
    chk("rf_raddr1", 64'(rf_raddr1), 64'd1);
    chk("rf_raddr2", 64'(rf_raddr2), 64'd2);
    send(32'h002081B3, 64'h100, 64'd5, 64'd7, mk(64'd5, 64'd7, 3'd0, 7'h00, 5'd3, 1'b1, 3'd0, 3'd0, 64'h100));
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    // SRAI x4,x5,3 and SRLI x4,x5,3
    send(32'h4032D213, 64'h104, 64'd11, 64'h55, mk(64'd11, 64'd3, 3'd5, 7'h20, 5'd4, 1'b1, 3'd0, 3'd0, 64'h104));
    send(32'h0032D213, 64'h108, 64'd12, 64'h55, mk(64'd12, 64'd3, 3'd5, 7'h00, 5'd4, 1'b1, 3'd0, 3'd0, 64'h108));
    // ADDI x1,x0,-1 : x0 reads zero whatever the regfile says
    send(32'hFFF00093, 64'h10C, 64'hDEAD, 64'h0, mk(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 7'h00, 5'd1, 1'b1, 3'd0, 3'd0, 64'h10C));
    // BEQ x1,x2,+8
    send(32'h00208463, 64'h110, 64'd3, 64'd4, mk(64'd3, 64'd4, 3'd0, 7'h20, 5'd0, 1'b0, 3'd3, 3'd0, 64'h110));
    // opcode 0x7F
    send(32'h0020827F, 64'h114, 64'd3, 64'd4, mk(64'd0, 64'd0, 3'd0, 7'h00, 5'd0, 1'b0, 3'd5, 3'd0, 64'h114));
    // LUI x5,0x80000
    send(32'h800002B7, 64'h118, 64'd1, 64'd2, mk(64'd0, 64'hFFFF_FFFF_8000_0000, 3'd0, 7'h00, 5'd5, 1'b1, 3'd0, 3'd0, 64'h118));
    // AUIPC x6,1
    send(32'h00001317, 64'h1000, 64'd1, 64'd2, mk(64'h1000, 64'h1000, 3'd0, 7'h00, 5'd6, 1'b1, 3'd0, 3'd0, 64'h1000));
    // JAL x1,0
    send(32'h000000EF, 64'h2000, 64'd1, 64'd2, mk(64'h2000, 64'd4, 3'd0, 7'h00, 5'd1, 1'b1, 3'd4, 3'd0, 64'h2000));
    // LW x7,-4(x1)
    send(32'hFFC0A383, 64'h2004, 64'd100, 64'd2, mk(64'd100, 64'hFFFF_FFFF_FFFF_FFFC, 3'd0, 7'h00, 5'd7, 1'b1, 3'd1, 3'd2, 64'h2004));
    // SW x2,8(x1)
    send(32'h0020A423, 64'h2008, 64'd200, 64'd9, mk(64'd200, 64'd8, 3'd0, 7'h00, 5'd0, 1'b0, 3'd2, 3'd2, 64'h2008));
    // ADDW x3,x1,x2 is not issued to the 64-bit ALU
    send(32'h002081BB, 64'h200C, 64'd1, 64'd2, mk(64'd0, 64'd0, 3'd0, 7'h00, 5'd0, 1'b0, 3'd5, 3'd0, 64'h200C));
    // SUB x3,x1,x2
    send(32'h402081B3, 64'h2010, 64'd10, 64'd3, mk(64'd10, 64'd3, 3'd0, 7'h20, 5'd3, 1'b1, 3'd0, 3'd0, 64'h2010));
    drain();

    // Backpressure: two entries held, third refused, then both issue in order
    out_ready = 1'b0;
    send(32'h002081B3, 64'h3000, 64'd21, 64'd22, mk(64'd21, 64'd22, 3'd0, 7'h00, 5'd3, 1'b1, 3'd0, 3'd0, 64'h3000));
    chk("bp_in_ready_one", 64'(in_ready), 64'd1);
    send(32'h402081B3, 64'h3004, 64'd31, 64'd32, mk(64'd31, 64'd32, 3'd0, 7'h20, 5'd3, 1'b1, 3'd0, 3'd0, 64'h3004));
    chk("bp_in_ready_full", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_instr = 32'hFFF00093;
    tick(acc);
    chk("bp_no_accept_full", 64'(acc), 64'd0);
    in_valid = 1'b0;
    chk("bp_held_pc", out_pc, 64'h3000);
    out_ready = 1'b1;
    drain();
    chk("bp_empty_after", 64'(out_valid), 64'd0);

    // Flush while FULL with in_valid high
    out_ready = 1'b0;
    send(32'h002081B3, 64'h4000, 64'd1, 64'd2, mk(64'd1, 64'd2, 3'd0, 7'h00, 5'd3, 1'b1, 3'd0, 3'd0, 64'h4000));
    send(32'h002081B3, 64'h4004, 64'd1, 64'd2, mk(64'd1, 64'd2, 3'd0, 7'h00, 5'd3, 1'b1, 3'd0, 3'd0, 64'h4004));
    in_valid = 1'b1; flush = 1'b1;
    tick(acc);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_out_valid", 64'(out_valid), 64'd0);
    chk("flush_full_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    repeat (3) tick(acc);

    // Flush in ONE while an accept is offered: the accept is discarded
    out_ready = 1'b0;
    send(32'h002081B3, 64'h5000, 64'd1, 64'd2, mk(64'd1, 64'd2, 3'd0, 7'h00, 5'd3, 1'b1, 3'd0, 3'd0, 64'h5000));
    in_valid = 1'b1; in_instr = 32'hFFF00093; flush = 1'b1;
    tick(acc);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_one_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) tick(acc);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    send(32'h002081B3, 64'h6000, 64'd77, 64'd2, mk(64'd77, 64'd2, 3'd0, 7'h00, 5'd3, 1'b1, 3'd0, 3'd0, 64'h6000));
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready",  64'(in_ready),  64'd1);
    chk("async_rst_alu_rs1",   alu_rs1,        64'd0);
    chk("async_rst_out_pc",    out_pc,         64'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Writeback bypass
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 64'd99;
`ifdef WB_FWD_EN
    send(32'h002081B3, 64'h7000, 64'd5, 64'd7, mk(64'd99, 64'd7, 3'd0, 7'h00, 5'd3, 1'b1, 3'd0, 3'd0, 64'h7000));
`else
    send(32'h002081B3, 64'h7000, 64'd5, 64'd7, mk(64'd5, 64'd7, 3'd0, 7'h00, 5'd3, 1'b1, 3'd0, 3'd0, 64'h7000));
`endif
    wb_rd = 5'd0;
    send(32'hFFF00093, 64'h7004, 64'd5, 64'd7, mk(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 7'h00, 5'd1, 1'b1, 3'd0, 3'd0, 64'h7004));
    wb_we = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
